nes_pad_receiver: RTL and testbench



---
 rtl/nes_pad_receiver_pkg.sv | 34 +++
 rtl/nes_pad_receiver_if.sv | 25 ++
 rtl/nes_pad_receiver_input_synchroniser.sv | 22 ++
 rtl/nes_pad_receiver.sv | 105 ++++++++++
 tb/tb_nes_pad_receiver.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/nes_pad_receiver_pkg.sv
// Shared definitions for the serial gamepad receiver: FSM encoding,
// button bit positions and stream lengths for NES / SNES pads.
package pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        RD_LOW,
        RD_HIGH,
        DONE
    } state_t;

    localparam int NES_BITS  = 8;
    localparam int SNES_BITS = 16;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int SNES_A     = 8;
    localparam int SNES_X     = 9;
    localparam int SNES_L     = 10;
    localparam int SNES_R     = 11;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nes_pad_receiver_if.sv
// Bundle between the pad receiver and its host/pads: poll request,
// pad wiring and the published button/connection words.
interface nes_pad_receiver_if #(
    parameter int NUM_PADS = 1,
    parameter int NUM_BITS = 8
);
    logic                         start;
    logic [NUM_PADS-1:0]          pad_data;
    logic                         pad_latch;
    logic                         pad_clk;
    logic [NUM_PADS*NUM_BITS-1:0] buttons;
    logic [NUM_PADS-1:0]          connected;
    logic                         valid;
    logic                         busy;

    modport master (
        output start, pad_data,
        input  pad_latch, pad_clk, buttons, connected, valid, busy
    );

    modport slave (
        input  start, pad_data,
        output pad_latch, pad_clk, buttons, connected, valid, busy
    );
endinterface

// File: rtl/nes_pad_receiver_input_synchroniser.sv
// Two-flop synchroniser for asynchronous pad data lines, one chain per bit.
module input_synchroniser #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/nes_pad_receiver.sv
// Polls NUM_PADS serial gamepads sharing one latch/clock pair and publishes
// active-high button words plus per-pad connection status once per start.
module nes_pad_receiver
    import pad_pkg::*;
#(
    parameter int NUM_PADS = 1,
    parameter int NUM_BITS = NES_BITS,
    parameter int CLK_DIV  = 4
) (
    input logic               clk,
    input logic               reset,
    nes_pad_receiver_if.slave bus
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = cnt_width(NUM_BITS);

    state_t                             state, state_nxt;
    logic   [TW-1:0]                    tick;
    logic                               latch_half;
    logic   [BW-1:0]                    bit_idx;
    logic   [NUM_PADS-1:0]              sync_data;
    logic   [NUM_PADS-1:0][NUM_BITS-1:0] shift_q, shift_nxt, frame_masked, buttons_q;
    logic   [NUM_PADS-1:0]              present, connected_q;
    logic                               tick_last, bit_last, sample;

    input_synchroniser #(.WIDTH(NUM_PADS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pad_data),
        .q     (sync_data)
    );

    assign tick_last = (tick == TW'(CLK_DIV - 1));
    assign bit_last  = (bit_idx == BW'(NUM_BITS - 1));
    assign sample    = (state == RD_LOW) && tick_last;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = LATCH;
            LATCH:   if (tick_last && latch_half) state_nxt = RD_LOW;
            RD_LOW:  if (tick_last) state_nxt = bit_last ? DONE : RD_HIGH;
            RD_HIGH: if (tick_last) state_nxt = RD_LOW;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.pad_latch = (state == LATCH);
        bus.pad_clk   = (state == RD_HIGH);
        bus.busy      = (state == LATCH) || (state == RD_LOW) || (state == RD_HIGH);
        bus.valid     = (state == DONE);
    end

    // LATCH spans two tick periods; latch_half marks the second one.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE || state == DONE) begin
            tick       <= '0;
            latch_half <= 1'b0;
            bit_idx    <= '0;
        end else begin
            tick <= tick_last ? '0 : tick + 1'b1;
            if (state == LATCH && tick_last)   latch_half <= ~latch_half;
            if (state == RD_HIGH && tick_last) bit_idx    <= bit_idx + 1'b1;
        end
    end

    // An all-ones inverted frame means the line sat low the whole poll: no pad.
    always_comb begin
        shift_nxt    = shift_q;
        frame_masked = '0;
        present      = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            shift_nxt[p][bit_idx] = ~sync_data[p];
            present[p]            = ~&shift_nxt[p];
            frame_masked[p]       = present[p] ? shift_nxt[p] : '0;
        end
    end

    // Published words change only on the final sample, together with entry into DONE.
    // NOTE: the shift registers are reset too, so the first frame after reset is never stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= '0;
            buttons_q   <= '0;
            connected_q <= '0;
        end else if (sample) begin
            shift_q <= shift_nxt;
            if (bit_last) begin
                buttons_q   <= frame_masked;
                connected_q <= present;
            end
        end
    end

    assign bus.buttons   = buttons_q;
    assign bus.connected = connected_q;
endmodule

// File: tb/tb_nes_pad_receiver.sv
// Directed bench for nes_pad_receiver: NES single pad, dual pad with an
// unplugged line, SNES timing, ignored restarts and mid-poll reset.
`timescale 1ns/1ps
module tb_nes_pad_receiver;
    import pad_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nes_pad_receiver_if #(.NUM_PADS(1), .NUM_BITS(8))  if_a ();
    nes_pad_receiver_if #(.NUM_PADS(2), .NUM_BITS(8))  if_b ();
    nes_pad_receiver_if #(.NUM_PADS(1), .NUM_BITS(16)) if_c ();

    nes_pad_receiver #(.NUM_PADS(1), .NUM_BITS(8), .CLK_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    nes_pad_receiver #(.NUM_PADS(2), .NUM_BITS(8), .CLK_DIV(4)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));
    nes_pad_receiver #(.NUM_PADS(1), .NUM_BITS(16), .CLK_DIV(6)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c.slave));

    // Pad models: load inverted frame on latch, shift on pad_clk rising edge.
    logic [7:0]  frame_a  = '0, sh_a  = '1;
    logic [7:0]  frame_b0 = '0, sh_b0 = '1;
    logic [7:0]  frame_b1 = '0, sh_b1 = '1;
    logic [15:0] frame_c  = '0, sh_c  = '1;
    logic        plug_b1  = 1'b1;
    int          edges_a = 0, edges_c = 0, latch_a = 0;

    always @(posedge if_a.pad_latch or posedge if_a.pad_clk)
        if (if_a.pad_latch) sh_a = ~frame_a;
        else                sh_a = {1'b1, sh_a[7:1]};

    always @(posedge if_b.pad_latch or posedge if_b.pad_clk)
        if (if_b.pad_latch) begin
            sh_b0 = ~frame_b0;
            sh_b1 = ~frame_b1;
        end else begin
            sh_b0 = {1'b1, sh_b0[7:1]};
            sh_b1 = {1'b1, sh_b1[7:1]};
        end

    always @(posedge if_c.pad_latch or posedge if_c.pad_clk)
        if (if_c.pad_latch) sh_c = ~frame_c;
        else                sh_c = {1'b1, sh_c[15:1]};

    always @(posedge if_a.pad_clk) edges_a++;
    always @(posedge if_c.pad_clk) edges_c++;
    always @(posedge clk) if (if_a.pad_latch) latch_a++;

    assign if_a.pad_data = sh_a[0];
    assign if_b.pad_data = {plug_b1 ? sh_b1[0] : 1'b0, sh_b0[0]};
    assign if_c.pad_data = sh_c[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       if_a.start = v;
            1:       if_b.start = v;
            default: if_c.start = v;
        endcase
    endtask

    function automatic logic get_valid(input int w);
        case (w)
            0:       return if_a.valid;
            1:       return if_b.valid;
            default: return if_c.valid;
        endcase
    endfunction

    // Entered at the negedge of the start cycle (cycle 0). Returns at the
    // negedge of cycle lat+1 with start low; lat = -1 on timeout.
    task automatic wait_valid(input int w, input int extra_cyc, input bit start_on_done,
                              output int lat);
        lat = -1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (get_valid(w)) begin
                lat = c;
                set_start(w, start_on_done);
                break;
            end
            set_start(w, c == extra_cyc);
        end
        @(negedge clk);
        set_start(w, 1'b0);
    endtask

    task automatic poll(input int w, input int extra_cyc, input bit start_on_done,
                        output int lat);
        @(negedge clk);
        set_start(w, 1'b1);
        wait_valid(w, extra_cyc, start_on_done, lat);
    endtask

    initial begin
        int lat, e0, l0, seen;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        if_c.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_a", {if_a.buttons, if_a.connected, if_a.valid, if_a.busy,
                              if_a.pad_latch, if_a.pad_clk}, '0);
        check("reset_out_b", {if_b.buttons, if_b.connected, if_b.busy}, '0);

        // NES Right+A, with ignored starts at cycle 20 and in DONE.
        frame_a = 8'((1 << BTN_RIGHT) | (1 << BTN_A));
        e0 = edges_a;
        l0 = latch_a;
        poll(0, 20, 1'b1, lat);
        check("nes_latency", lat, 69);
        check("nes_buttons", if_a.buttons, 8'b1000_0001);
        check("nes_connected", if_a.connected, 1'b1);
        check("after_done_busy", if_a.busy, 1'b0);
        check("after_done_latch", if_a.pad_latch, 1'b0);
        repeat (10) @(negedge clk);
        check("no_restart_busy", if_a.busy, 1'b0);
        check("latch_clocks", latch_a - l0, 8);
        check("pad_clk_edges", edges_a - e0, 7);

        // Pad with nothing pressed, then a fresh start in the first IDLE cycle.
        frame_a = 8'h00;
        poll(0, -1, 1'b0, lat);
        check("none_latency", lat, 69);
        check("none_buttons", if_a.buttons, 8'h00);
        check("none_connected", if_a.connected, 1'b1);
        frame_a = 8'((1 << BTN_SELECT) | (1 << BTN_DOWN));
        set_start(0, 1'b1);
        wait_valid(0, -1, 1'b0, lat);
        check("idle_restart_latency", lat, 69);
        check("idle_restart_buttons", if_a.buttons, 8'h24);

        // Reset asserted at cycle 40 of a poll.
        frame_a = 8'hFF;
        @(negedge clk);
        set_start(0, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            set_start(0, 1'b0);
            if (c == 40) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        check("midreset_latch", if_a.pad_latch, 1'b0);
        check("midreset_pad_clk", if_a.pad_clk, 1'b0);
        check("midreset_busy", if_a.busy, 1'b0);
        check("midreset_buttons", if_a.buttons, 8'h00);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (if_a.valid) seen++;
        end
        check("midreset_no_valid", seen, 0);

        // Two pads in one poll.
        frame_b0 = 8'(1 << BTN_UP);
        frame_b1 = 8'((1 << BTN_START) | (1 << BTN_B));
        plug_b1  = 1'b1;
        poll(1, -1, 1'b0, lat);
        check("dual_latency", lat, 69);
        check("dual_buttons", if_b.buttons, 16'b0000_1010_0001_0000);
        check("dual_connected", if_b.connected, 2'b11);

        // Pad 1 unplugged (line held low), pad 0 idle.
        frame_b0 = 8'h00;
        frame_b1 = 8'hFF;
        plug_b1  = 1'b0;
        poll(1, -1, 1'b0, lat);
        check("unplug_buttons", if_b.buttons, 16'h0000);
        check("unplug_connected", if_b.connected, 2'b01);

        // SNES pad, L+R, CLK_DIV 6.
        frame_c = 16'((1 << SNES_L) | (1 << SNES_R));
        e0 = edges_c;
        poll(2, -1, 1'b0, lat);
        check("snes_latency", lat, 199);
        check("snes_buttons", if_c.buttons, 16'h0C00);
        check("snes_connected", if_c.connected, 1'b1);
        check("snes_pad_clk_edges", edges_c - e0, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
